risc_controller: RTL and testbench
==================================

// Module: risc_controller
// PURPOSE
//  Instruction sequencer for the RISC core. Steps an 8-phase fetch/execute cycle, decodes the IR opcode,
//  and issues per-phase strobes to memory, PC, IR, accumulator and the data-bus tri-state driver.
//  Sits directly upstream of the bus driver: its data_e output is that driver's data_en.
// PARAMETERS
//  OPC_WIDTH    3  opcode width; fixed at 3, other values unsupported.
//  START_PHASE  0  phase entered on reset release. Legal values 0..7. Default INST_ADDR.
// PORTS
//  clk     in   1          system clock; all state changes on the rising edge.
//  rst_    in   1          reset; asynchronous, active-low.
//  opcode  in   OPC_WIDTH  IR[7:5]; sampled combinationally; stable from phase 3 to phase 7.
//  zero    in   1          accumulator==0 flag.
//  sel     out  1          1 = PC drives the address bus; 0 = IR operand field drives it.
//  rd      out  1          memory read strobe.
//  ld_ir   out  1          IR load enable.
//  inc_pc  out  1          PC increment enable.
//  ld_pc   out  1          PC load enable; JMP only.
//  ld_ac   out  1          accumulator load enable.
//  wr      out  1          memory write strobe.
//  data_e  out  1          bus driver enable; accumulator drives the data bus.
//  halt    out  1          core halted.
// BEHAVIOUR
//  - Reset (async, rst_=0): phase=START_PHASE, halted=0.
//    All outputs come from the phase decode of START_PHASE; with the default all outputs are 0 except sel=1.
//  - Phase counter: 3 bits, advances by 1 on each clk while not halted; wraps 7->0.
//  - Opcodes: HLT=0 SKZ=1 ADD=2 AND=3 XOR=4 LDA=5 STO=6 JMP=7.
//  - ALUOP = ADD|AND|XOR|LDA.
//  - Outputs are combinational decodes of (phase, opcode, zero, halted). No extra latency.
//    0 INST_ADDR : sel
//    1 INST_FETCH: sel rd
//    2 INST_LOAD : sel rd ld_ir
//    3 IDLE      : sel rd ld_ir
//    4 OP_ADDR   : inc_pc; halt if opcode==HLT
//    5 OP_FETCH  : rd=ALUOP
//    6 ALU_OP    : rd=ALUOP, inc_pc=(SKZ&&zero), ld_pc=JMP, data_e=STO
//    7 STORE     : rd=ALUOP, ld_ac=ALUOP, ld_pc=JMP, wr=STO, data_e=STO
//  - HLT: on the clk edge leaving phase 4 with opcode==HLT, halted<=1 and the phase freezes at 5.
//    While halted:
//      - halt=1;
//      - every other strobe (rd, ld_ir, inc_pc, ld_pc, ld_ac, wr, data_e) is 0; sel is 0;
//      - the counter does not advance.
//    Only reset (or resume, see below) exits the halted condition.
//  - wr and data_e are never 1 outside phases 6..7; wr only in phase 7. The driver is enabled one phase
//    ahead of wr, so the bus is settled before the write.
//  - Reset asserted mid-cycle: outputs go immediately to the START_PHASE decode. No partial strobe survives.
//  - X on opcode in phases 0..3 must not affect the outputs.
// CONFIGURATION
//  RISC_CTRL_RESUME_EN defined:
//    - adds input port `resume` (1 bit);
//    - resume=1 while halted: halted<=0 and phase<=INST_ADDR on the next edge; PC was already
//      incremented in phase 4, so execution continues at the next instruction;
//    - resume is ignored when not halted.
//  RISC_CTRL_RESUME_EN not defined: no resume port; halt is sticky until rst_.
// STRUCTURE
//  - Package risc_pkg holds:
//    - opcode localparams (OPC_HLT..OPC_JMP);
//    - phase localparams (PH_INST_ADDR..PH_STORE);
//    - the ALUOP membership function.
//    All three are shared with the ALU and testbenches.
//  - Sub-module risc_phase_counter: 3-bit wrapping counter with async active-low reset, load and
//    enable. Enable is driven by !halted.
//  - Top level is the decode plus the halt flop.
// TESTING
//  1 rst_=0 then 1, opcode=LDA(5): phases 0..7 in order; ld_ir=1 in phases 2,3; ld_ac=1 only in phase 7;
//    wr=0 and data_e=0 throughout.
//  2 opcode=STO(6): data_e=1 in phases 6,7; wr=1 only in phase 7; rd=0 in phases 5..7.
//  3 opcode=SKZ(1) with zero=1: inc_pc=1 in phases 4 and 6. With zero=0: inc_pc=1 in phase 4 only.
//  4 opcode=JMP(7): ld_pc=1 in phases 6,7; ld_ac=0; wr=0.
//  5 opcode=HLT(0): at phase 4 halt=1; after the edge halted holds for 20 clocks with all other strobes 0.
//    With the macro: resume=1 gives phase 0 and sel=1 next cycle.
//  6 Pull rst_ low asynchronously at phase 6 with STO: data_e drops to 0 before the next clk edge;
//    phase=START_PHASE after release.

Source files
------------

// File: rtl/risc_pkg.sv
// Shared definitions for the RISC core: opcodes, sequencer phases and the
// ALU-opcode membership test. Used by the controller, the ALU and benches.
package risc_pkg;

    localparam int unsigned OPC_W = 3;

    localparam logic [OPC_W-1:0] OPC_HLT = 3'd0;
    localparam logic [OPC_W-1:0] OPC_SKZ = 3'd1;
    localparam logic [OPC_W-1:0] OPC_ADD = 3'd2;
    localparam logic [OPC_W-1:0] OPC_AND = 3'd3;
    localparam logic [OPC_W-1:0] OPC_XOR = 3'd4;
    localparam logic [OPC_W-1:0] OPC_LDA = 3'd5;
    localparam logic [OPC_W-1:0] OPC_STO = 3'd6;
    localparam logic [OPC_W-1:0] OPC_JMP = 3'd7;

    typedef enum logic [2:0] {
        PH_INST_ADDR  = 3'd0,
        PH_INST_FETCH = 3'd1,
        PH_INST_LOAD  = 3'd2,
        PH_IDLE       = 3'd3,
        PH_OP_ADDR    = 3'd4,
        PH_OP_FETCH   = 3'd5,
        PH_ALU_OP     = 3'd6,
        PH_STORE      = 3'd7
    } phase_t;

    // Opcodes that read an operand and load the accumulator
    function automatic logic is_aluop(input logic [OPC_W-1:0] opc);
        return (opc == OPC_ADD) || (opc == OPC_AND) ||
               (opc == OPC_XOR) || (opc == OPC_LDA);
    endfunction

endpackage

// File: rtl/risc_phase_counter.sv
// 3-bit wrapping phase counter with async active-low reset, synchronous
// load (priority over enable) and count enable.
module risc_phase_counter #(
    parameter logic [2:0] RESET_VAL = 3'd0
) (
    input  logic       clk,
    input  logic       rst_,
    input  logic       load,
    input  logic [2:0] load_val,
    input  logic       en,
    output logic [2:0] count
);

    // Phase register: reset value, then load or advance with natural wrap 7->0
    always_ff @(posedge clk or negedge rst_) begin
        if (!rst_) begin
            count <= RESET_VAL;
        end else if (load) begin
            count <= load_val;
        end else if (en) begin
            count <= count + 3'd1;
        end
    end

endmodule

// File: rtl/risc_controller.sv
// Instruction sequencer for the RISC core: 8-phase fetch/execute cycle,
// opcode decode and per-phase strobes. data_e feeds the bus driver's data_en.
// Optional feature: define RISC_CTRL_RESUME_EN to add the `resume` input,
// which leaves the halted state and restarts at INST_ADDR.
module risc_controller
    import risc_pkg::*;
#(
    parameter int unsigned OPC_WIDTH   = 3,
    parameter int unsigned START_PHASE = 0
) (
    input  logic                 clk,
    input  logic                 rst_,
    input  logic [OPC_WIDTH-1:0] opcode,
    input  logic                 zero,
`ifdef RISC_CTRL_RESUME_EN
    input  logic                 resume,
`endif
    output logic                 sel,
    output logic                 rd,
    output logic                 ld_ir,
    output logic                 inc_pc,
    output logic                 ld_pc,
    output logic                 ld_ac,
    output logic                 wr,
    output logic                 data_e,
    output logic                 halt
);

    logic [2:0] count;
    phase_t     phase;
    logic       halted;
    logic       halt_set;
    logic       resume_go;
    logic       aluop;

    assign phase = phase_t'(count);
    assign aluop = is_aluop(opcode);

    // Opcode is only qualified in phase 4, so an unknown opcode earlier is harmless
    assign halt_set = (phase == PH_OP_ADDR) && !halted && (opcode == OPC_HLT);

`ifdef RISC_CTRL_RESUME_EN
    assign resume_go = halted && resume;
`else
    assign resume_go = 1'b0;
`endif

    risc_phase_counter #(
        .RESET_VAL (3'(START_PHASE))
    ) u_phase_counter (
        .clk      (clk),
        .rst_     (rst_),
        .load     (resume_go),
        .load_val (PH_INST_ADDR),
        .en       (!halted),
        .count    (count)
    );

    // Halt flag: set leaving phase 4 on HLT (counter lands on 5 and freezes)
    always_ff @(posedge clk or negedge rst_) begin
        if (!rst_) begin
            halted <= 1'b0;
        end else if (resume_go) begin
            halted <= 1'b0;
        end else if (halt_set) begin
            halted <= 1'b1;
        end
    end

    // Strobe decode from phase, opcode, zero flag and halted state
    always_comb begin
        sel    = 1'b0;
        rd     = 1'b0;
        ld_ir  = 1'b0;
        inc_pc = 1'b0;
        ld_pc  = 1'b0;
        ld_ac  = 1'b0;
        wr     = 1'b0;
        data_e = 1'b0;
        halt   = 1'b0;
        if (halted) begin
            halt = 1'b1;
        end else begin
            unique case (phase)
                PH_INST_ADDR: begin
                    sel = 1'b1;
                end
                PH_INST_FETCH: begin
                    sel = 1'b1;
                    rd  = 1'b1;
                end
                PH_INST_LOAD, PH_IDLE: begin
                    sel   = 1'b1;
                    rd    = 1'b1;
                    ld_ir = 1'b1;
                end
                PH_OP_ADDR: begin
                    inc_pc = 1'b1;
                    halt   = (opcode == OPC_HLT);
                end
                PH_OP_FETCH: begin
                    rd = aluop;
                end
                PH_ALU_OP: begin
                    rd     = aluop;
                    inc_pc = (opcode == OPC_SKZ) && zero;
                    ld_pc  = (opcode == OPC_JMP);
                    data_e = (opcode == OPC_STO);
                end
                PH_STORE: begin
                    rd     = aluop;
                    ld_ac  = aluop;
                    ld_pc  = (opcode == OPC_JMP);
                    wr     = (opcode == OPC_STO);
                    data_e = (opcode == OPC_STO);
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_risc_controller.sv
// Directed self-checking bench for risc_controller. Output vector order:
// {sel, rd, ld_ir, inc_pc, ld_pc, ld_ac, wr, data_e, halt}.
module tb_risc_controller;
    import risc_pkg::*;

    logic       clk = 1'b0;
    logic       rst_ = 1'b0;
    logic [2:0] opcode = 3'd0;
    logic       zero = 1'b0;
`ifdef RISC_CTRL_RESUME_EN
    logic       resume = 1'b0;
`endif
    logic sel, rd, ld_ir, inc_pc, ld_pc, ld_ac, wr, data_e, halt;
    logic [8:0] outs;

    int unsigned n_checks = 0;
    int unsigned n_fail   = 0;

    assign outs = {sel, rd, ld_ir, inc_pc, ld_pc, ld_ac, wr, data_e, halt};

    always #5 clk = ~clk;

    risc_controller #(
        .OPC_WIDTH   (3),
        .START_PHASE (0)
    ) dut (
        .clk    (clk),
        .rst_   (rst_),
        .opcode (opcode),
        .zero   (zero),
`ifdef RISC_CTRL_RESUME_EN
        .resume (resume),
`endif
        .sel    (sel),
        .rd     (rd),
        .ld_ir  (ld_ir),
        .inc_pc (inc_pc),
        .ld_pc  (ld_pc),
        .ld_ac  (ld_ac),
        .wr     (wr),
        .data_e (data_e),
        .halt   (halt)
    );

    task automatic check(input string tag, input logic [8:0] actual, input logic [8:0] expected);
        n_checks++;
        if (actual !== expected) begin
            n_fail++;
            $display("FAIL %s: got %b expected %b", tag, actual, expected);
        end
    endtask

    // Hand-computed per-phase output tables
    localparam logic [8:0] EXP_LDA   [8] = '{9'b100000000, 9'b110000000, 9'b111000000, 9'b111000000,
                                             9'b000100000, 9'b010000000, 9'b010000000, 9'b010001000};
    localparam logic [8:0] EXP_STO   [8] = '{9'b100000000, 9'b110000000, 9'b111000000, 9'b111000000,
                                             9'b000100000, 9'b000000000, 9'b000000010, 9'b000000110};
    localparam logic [8:0] EXP_SKZ_1 [8] = '{9'b100000000, 9'b110000000, 9'b111000000, 9'b111000000,
                                             9'b000100000, 9'b000000000, 9'b000100000, 9'b000000000};
    localparam logic [8:0] EXP_SKZ_0 [8] = '{9'b100000000, 9'b110000000, 9'b111000000, 9'b111000000,
                                             9'b000100000, 9'b000000000, 9'b000000000, 9'b000000000};
    localparam logic [8:0] EXP_JMP   [8] = '{9'b100000000, 9'b110000000, 9'b111000000, 9'b111000000,
                                             9'b000100000, 9'b000000000, 9'b000010000, 9'b000010000};
    localparam logic [8:0] EXP_HLT   [5] = '{9'b100000000, 9'b110000000, 9'b111000000, 9'b111000000,
                                             9'b000100001};

    // Reset, release between edges, then check phases 0..last
    task automatic start_cycle(input string name, input logic [2:0] opc, input logic z);
        rst_ = 1'b0;
        @(negedge clk);
        opcode = opc;
        zero   = z;
        #1 check({name, "_reset"}, outs, 9'b100000000);
        #1 rst_ = 1'b1;
        #1 check({name, "_ph0"}, outs, 9'b100000000);
    endtask

    task automatic run_full(input string name, input logic [2:0] opc, input logic z,
                            input logic [8:0] exp_tab [8]);
        start_cycle(name, opc, z);
        for (int p = 1; p < 8; p++) begin
            @(posedge clk);
            #1 check($sformatf("%s_ph%0d", name, p), outs, exp_tab[p]);
        end
    endtask

    initial begin
        // 1: LDA through all phases plus wrap back to phase 0
        run_full("lda", OPC_LDA, 1'b0, EXP_LDA);
        @(posedge clk);
        #1 check("lda_wrap_ph0", outs, 9'b100000000);
        @(posedge clk);
        #1 check("lda_wrap_ph1", outs, 9'b110000000);

        // 2: STO
        run_full("sto", OPC_STO, 1'b0, EXP_STO);

        // 3: SKZ with zero set and clear
        run_full("skz_z1", OPC_SKZ, 1'b1, EXP_SKZ_1);
        run_full("skz_z0", OPC_SKZ, 1'b0, EXP_SKZ_0);

        // 4: JMP
        run_full("jmp", OPC_JMP, 1'b0, EXP_JMP);

        // 5: HLT, then 20 frozen cycles even with a different opcode present
        start_cycle("hlt", OPC_HLT, 1'b0);
        for (int p = 1; p < 5; p++) begin
            @(posedge clk);
            #1 check($sformatf("hlt_ph%0d", p), outs, EXP_HLT[p]);
        end
        @(posedge clk);
        #1 check("hlt_halted", outs, 9'b000000001);
        opcode = OPC_STO;
        zero   = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(posedge clk);
            #1 check($sformatf("hlt_hold%0d", i), outs, 9'b000000001);
        end
`ifdef RISC_CTRL_RESUME_EN
        @(negedge clk);
        resume = 1'b1;
        @(posedge clk);
        #1 check("resume_ph0", outs, 9'b100000000);
        resume = 1'b0;
        @(posedge clk);
        #1 check("resume_ph1", outs, 9'b110000000);
`endif

        // 6: async reset during STO phase 6 clears data_e before the next edge
        start_cycle("rst", OPC_STO, 1'b0);
        for (int p = 1; p < 7; p++) begin
            @(posedge clk);
            #1 check($sformatf("rst_ph%0d", p), outs, EXP_STO[p]);
        end
        #1 rst_ = 1'b0;
        #1 check("rst_async", outs, 9'b100000000);
        @(posedge clk);
        #1 check("rst_held", outs, 9'b100000000);
        @(negedge clk);
        rst_ = 1'b1;
        #1 check("rst_rel_ph0", outs, 9'b100000000);
        @(posedge clk);
        #1 check("rst_rel_ph1", outs, 9'b110000000);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
